pcileech_ft601_emu: RTL and testbench

- Synthesizable device-side model of the FT601 245-synchronous FIFO bus. It is the chip end of the bus that the FPGA-side FT601 controller masters.
- Used for on-board loopback and simulation:
  - A host-side stream fills the RX FIFO, which the FPGA reads through RXF_N/OE_N/RD_N.
  - Words written by the FPGA through TXE_N/WR_N land in the TX FIFO, which drains to a host-side stream.
- The bus is split into separate in, out and output-enable signals. The top level builds the tristate.

---
 rtl/pcileech_ft601_emu_pkg.sv | 14 +
 rtl/pcileech_ft601_emu_if.sv | 12 +
 rtl/pcileech_ft601_emu_fifo.sv | 57 +++++
 rtl/pcileech_ft601_emu.sv | 161 ++++++++++++++++
 tb/tb_pcileech_ft601_emu.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcileech_ft601_emu_pkg.sv
// pcileech_ft601_emu shared package:
// byte-order helper and err_flags bit map.
package pcileech_ft601_pkg;

  localparam int ERR_RX_UNDERRUN  = 0;
  localparam int ERR_TX_OVERRUN   = 1;
  localparam int ERR_BUS_CONFLICT = 2;
  localparam int ERR_BE           = 3;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/pcileech_ft601_emu_if.sv
// Word stream valid/ready bundle used
// between the bus logic and the FIFOs.
interface pcileech_ft601_emu_if;

  logic [31:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/pcileech_ft601_emu_fifo.sv
// Synchronous FWFT FIFO; also reports the
// head word and count as they will be after this edge.
module pcileech_ft601_emu_fifo #(
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pcileech_ft601_emu_if.slave  push,
  pcileech_ft601_emu_if.master pop,
  output logic [31:0]          head_nxt,
  output logic [AW:0]          count_nxt
);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [31:0] mem_q [0:(1<<AW)-1];
  logic        full;
  logic        empty;
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) &&
              (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push.valid & ~full;
    do_pop  = pop.ready & ~empty;
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    count_nxt = wr_d - rd_d;
    // a word pushed into the slot the head moves to bypasses the array
    if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0]))
      head_nxt = push.data;
    else
      head_nxt = mem_q[rd_d[AW-1:0]];
  end

  assign push.ready = ~full;
  assign pop.valid  = ~empty;
  assign pop.data   = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q[AW-1:0]] <= push.data;
  end

endmodule

// File: rtl/pcileech_ft601_emu.sv
// FT601 245-sync FIFO device-side model.
// Optional TX stall: PCILEECH_FT601_EMU_TXBURST_EN.
module pcileech_ft601_emu #(
  parameter int RX_DEPTH_LOG2  = 4,
  parameter int TX_DEPTH_LOG2  = 4,
  parameter int TX_BURST_WORDS = 8,
  parameter int TX_HOLDOFF     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ft_data_i,
  output logic [31:0] ft_data_o,
  output logic        ft_data_oe,
  input  logic [3:0]  ft_be_i,
  output logic        ft_rxf_n,
  output logic        ft_txe_n,
  input  logic        ft_oe_n,
  input  logic        ft_rd_n,
  input  logic        ft_wr_n,
  input  logic        ft_siwu_n,
  input  logic [31:0] host_din,
  input  logic        host_din_valid,
  output logic        host_din_ready,
  output logic [31:0] host_dout,
  output logic        host_dout_valid,
  input  logic        host_dout_ready,
  output logic [3:0]  err_flags
);
  import pcileech_ft601_pkg::*;

  localparam logic [TX_DEPTH_LOG2:0] TX_FULL =
    {1'b1, {TX_DEPTH_LOG2{1'b0}}};

  pcileech_ft601_emu_if rx_in ();
  pcileech_ft601_emu_if rx_out ();
  pcileech_ft601_emu_if tx_in ();
  pcileech_ft601_emu_if tx_out ();

  logic [RX_DEPTH_LOG2:0] rx_cnt_nxt;
  logic [TX_DEPTH_LOG2:0] tx_cnt_nxt;
  logic [31:0]            rx_head_nxt;
  logic [31:0]            tx_head_nxt;
  logic [31:0]            data_o_q, data_o_d;
  logic                   data_oe_q, data_oe_d;
  logic                   rxf_n_q, rxf_n_d;
  logic                   txe_n_q, txe_n_d;
  logic [3:0]             err_q, err_d;
  logic                   hold_off;
  logic                   unused_ok;

  assign rx_in.data      = host_din;
  assign rx_in.valid     = host_din_valid;
  assign host_din_ready  = rx_in.ready;
  assign rx_out.ready    = ~ft_oe_n & ~ft_rd_n;
  assign tx_in.data      = byteswap32(ft_data_i);
  assign tx_in.valid     = ~ft_wr_n & ~txe_n_q;
  assign tx_out.ready    = host_dout_ready;
  assign host_dout       = tx_out.data;
  assign host_dout_valid = tx_out.valid;

  pcileech_ft601_emu_fifo #(.AW(RX_DEPTH_LOG2)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_in),
    .pop       (rx_out),
    .head_nxt  (rx_head_nxt),
    .count_nxt (rx_cnt_nxt)
  );

  pcileech_ft601_emu_fifo #(.AW(TX_DEPTH_LOG2)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_in),
    .pop       (tx_out),
    .head_nxt  (tx_head_nxt),
    .count_nxt (tx_cnt_nxt)
  );

`ifdef PCILEECH_FT601_EMU_TXBURST_EN
  localparam int BCW = $clog2(TX_BURST_WORDS + 1);
  localparam int HCW = $clog2(TX_HOLDOFF + 1);

  logic [BCW-1:0] burst_q, burst_d;
  logic [HCW-1:0] hold_q, hold_d;

  always_comb begin
    burst_d = burst_q;
    hold_d  = (hold_q != '0) ? hold_q - HCW'(1) : hold_q;
    if (tx_in.valid) begin
      burst_d = burst_q + BCW'(1);
      if (burst_d == BCW'(TX_BURST_WORDS)) begin
        burst_d = '0;
        hold_d  = HCW'(TX_HOLDOFF);
      end
    end
  end

  assign hold_off = (hold_d != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= '0;
      hold_q  <= '0;
    end else begin
      burst_q <= burst_d;
      hold_q  <= hold_d;
    end
  end

  assign unused_ok = ft_siwu_n ^ tx_in.ready ^
                     (^rx_out.data) ^ (^tx_head_nxt);
`else
  assign hold_off  = 1'b0;
  assign unused_ok = ft_siwu_n ^ tx_in.ready ^
                     (^rx_out.data) ^ (^tx_head_nxt) ^
                     (TX_BURST_WORDS != 0) ^ (TX_HOLDOFF != 0);
`endif

  always_comb begin
    // bus keeps its last word once nothing is left to show
    data_o_d  = (rx_cnt_nxt == '0) ? data_o_q
                                   : byteswap32(rx_head_nxt);
    data_oe_d = ~ft_oe_n;
    rxf_n_d   = (rx_cnt_nxt == '0);
    txe_n_d   = (tx_cnt_nxt == TX_FULL) | hold_off;
    err_d     = err_q;
    if (~ft_rd_n & ~rx_out.valid)
      err_d[ERR_RX_UNDERRUN] = 1'b1;
    if (~ft_wr_n & txe_n_q)
      err_d[ERR_TX_OVERRUN] = 1'b1;
    if ((~ft_wr_n & ~ft_oe_n) |
        (~ft_rd_n & ft_oe_n) |
        (~ft_wr_n & data_oe_q))
      err_d[ERR_BUS_CONFLICT] = 1'b1;
    if (~ft_wr_n & (ft_be_i != 4'hF))
      err_d[ERR_BE] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o_q  <= '0;
      data_oe_q <= 1'b0;
      rxf_n_q   <= 1'b1;
      txe_n_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      data_o_q  <= data_o_d;
      data_oe_q <= data_oe_d;
      rxf_n_q   <= rxf_n_d;
      txe_n_q   <= txe_n_d;
      err_q     <= err_d;
    end
  end

  assign ft_data_o  = data_o_q;
  assign ft_data_oe = data_oe_q;
  assign ft_rxf_n   = rxf_n_q;
  assign ft_txe_n   = txe_n_q;
  assign err_flags  = err_q;

endmodule

// File: tb/tb_pcileech_ft601_emu.sv
// Bench for pcileech_ft601_emu: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_pcileech_ft601_emu;

  localparam int RXD = 16;
  localparam int TXD = 16;
  localparam int BURST = 8;
  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ft_data_i;
  logic [31:0] ft_data_o;
  logic        ft_data_oe;
  logic [3:0]  ft_be_i;
  logic        ft_rxf_n, ft_txe_n;
  logic        ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n;
  logic [3:0]  err_flags;

  pcileech_ft601_emu_if hin ();
  pcileech_ft601_emu_if hout ();

  pcileech_ft601_emu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ft_data_i       (ft_data_i),
    .ft_data_o       (ft_data_o),
    .ft_data_oe      (ft_data_oe),
    .ft_be_i         (ft_be_i),
    .ft_rxf_n        (ft_rxf_n),
    .ft_txe_n        (ft_txe_n),
    .ft_oe_n         (ft_oe_n),
    .ft_rd_n         (ft_rd_n),
    .ft_wr_n         (ft_wr_n),
    .ft_siwu_n       (ft_siwu_n),
    .host_din        (hin.data),
    .host_din_valid  (hin.valid),
    .host_din_ready  (hin.ready),
    .host_dout       (hout.data),
    .host_dout_valid (hout.valid),
    .host_dout_ready (hout.ready),
    .err_flags       (err_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] rxq[$];
  logic [31:0] txq[$];
  logic [31:0] hgot[$];
  logic [31:0] m_data;
  logic        m_oe, m_rxf, m_txe;
  logic [3:0]  m_err;
  int          m_bc, m_hold;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    bswap = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_data = '0;
    m_oe = 1'b0;
    m_rxf = 1'b1;
    m_txe = 1'b0;
    m_err = '0;
    m_bc = 0;
    m_hold = 0;
  endtask

  task automatic idle();
    ft_oe_n = 1'b1;
    ft_rd_n = 1'b1;
    ft_wr_n = 1'b1;
    ft_be_i = 4'hF;
    ft_data_i = '0;
    ft_siwu_n = 1'b1;
    hin.valid = 1'b0;
    hin.data = '0;
    hout.ready = 1'b0;
  endtask

  // advance one clock, applying the chip's rules to the model
  task automatic step();
    int rxn, txn;
    bit rpush, rpop, tpush, tpop;
    rxn = rxq.size();
    txn = txq.size();
    rpush = hin.valid && (rxn < RXD);
    rpop = !ft_oe_n && !ft_rd_n && (rxn > 0);
    tpush = !ft_wr_n && !m_txe;
    tpop = hout.ready && (txn > 0);
    if (!ft_rd_n && rxn == 0) m_err[0] = 1'b1;
    if (!ft_wr_n && m_txe) m_err[1] = 1'b1;
    if ((!ft_wr_n && !ft_oe_n) || (!ft_rd_n && ft_oe_n) ||
        (!ft_wr_n && m_oe)) m_err[2] = 1'b1;
    if (!ft_wr_n && ft_be_i != 4'hF) m_err[3] = 1'b1;
    if (tpop) begin
      hgot.push_back(hout.data);
      void'(txq.pop_front());
    end
    if (rpop) void'(rxq.pop_front());
    if (rpush) rxq.push_back(hin.data);
    if (tpush) txq.push_back(bswap(ft_data_i));
    if (rxq.size() > 0) m_data = bswap(rxq[0]);
    m_oe = !ft_oe_n;
    m_rxf = (rxq.size() == 0);
`ifdef PCILEECH_FT601_EMU_TXBURST_EN
    if (m_hold > 0) m_hold--;
    if (tpush) begin
      m_bc++;
      if (m_bc == BURST) begin
        m_bc = 0;
        m_hold = HOLD;
      end
    end
`endif
    m_txe = (txq.size() == TXD) || (m_hold > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    hgot.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ft_rxf_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_rxf_n got=%0b exp=1", ft_rxf_n);
    end
    checks++;
    if (ft_txe_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_txe_n got=%0b exp=0", ft_txe_n);
    end
    checks++;
    if (ft_data_oe !== 1'b0 || ft_data_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got oe=%0b d=%h exp 0/0",
               ft_data_oe, ft_data_o);
    end
    checks++;
    if (hout.valid !== 1'b0 || err_flags !== 4'h0) begin
      failures++;
      $display("FAIL reset_host got v=%0b err=%h exp 0/0",
               hout.valid, err_flags);
    end
    checks++;
    if (hin.ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_din_ready got=%0b exp=1", hin.ready);
    end
  endtask

  task automatic test_rx_read();
    do_reset();
    hin.valid = 1'b1;
    hin.data = 32'h11223344;
    step();
    hin.data = 32'hAABBCCDD;
    step();
    hin.valid = 1'b0;
    checks++;
    if (ft_rxf_n !== 1'b0) begin
      failures++;
      $display("FAIL rx_rxf_after_push got=%0b exp=0", ft_rxf_n);
    end
    ft_oe_n = 1'b0;
    step();
    checks++;
    if (ft_data_o !== 32'h44332211 || ft_data_oe !== 1'b1) begin
      failures++;
      $display("FAIL rx_first got d=%h oe=%0b exp 44332211/1",
               ft_data_o, ft_data_oe);
    end
    ft_rd_n = 1'b0;
    step();
    checks++;
    if (ft_data_o !== 32'hDDCCBBAA || ft_rxf_n !== 1'b0) begin
      failures++;
      $display("FAIL rx_second got d=%h rxf=%0b exp ddccbbaa/0",
               ft_data_o, ft_rxf_n);
    end
    step();
    ft_rd_n = 1'b1;
    checks++;
    if (ft_rxf_n !== 1'b1 || err_flags !== 4'h0) begin
      failures++;
      $display("FAIL rx_drained got rxf=%0b err=%h exp 1/0",
               ft_rxf_n, err_flags);
    end
    ft_oe_n = 1'b1;
    step();
    checks++;
    if (ft_data_oe !== 1'b0 || ft_data_o !== 32'hDDCCBBAA) begin
      failures++;
      $display("FAIL rx_turnoff got oe=%0b d=%h exp 0/ddccbbaa",
               ft_data_oe, ft_data_o);
    end
  endtask

  task automatic test_tx_write();
    do_reset();
    ft_wr_n = 1'b0;
    ft_data_i = 32'h01020304;
    step();
    ft_wr_n = 1'b1;
    checks++;
    if (hout.data !== 32'h04030201 || hout.valid !== 1'b1) begin
      failures++;
      $display("FAIL tx_write got d=%h v=%0b exp 04030201/1",
               hout.data, hout.valid);
    end
    hout.ready = 1'b1;
    step();
    hout.ready = 1'b0;
    checks++;
    if (hout.valid !== 1'b0 || ft_txe_n !== 1'b0) begin
      failures++;
      $display("FAIL tx_drain got v=%0b txe=%0b exp 0/0",
               hout.valid, ft_txe_n);
    end
  endtask

  task automatic fill_tx(output logic [31:0] sent[$]);
    logic [31:0] w;
    sent.delete();
    for (int g = 0; g < 100 && sent.size() < TXD; g++) begin
      w = $urandom;
      ft_wr_n = 1'b0;
      ft_data_i = w;
      if (!m_txe) sent.push_back(bswap(w));
      step();
    end
    ft_wr_n = 1'b1;
  endtask

  task automatic test_tx_fill();
    logic [31:0] sent[$];
    do_reset();
    fill_tx(sent);
    checks++;
    if (ft_txe_n !== 1'b1) begin
      failures++;
      $display("FAIL fill_txe got=%0b exp=1", ft_txe_n);
    end
    ft_wr_n = 1'b0;
    ft_data_i = $urandom;
    step();
    ft_wr_n = 1'b1;
    checks++;
    if (err_flags[1] !== 1'b1) begin
      failures++;
      $display("FAIL fill_overrun got=%0b exp=1", err_flags[1]);
    end
    hgot.delete();
    hout.ready = 1'b1;
    for (int g = 0; g < 40 && hout.valid === 1'b1; g++) step();
    hout.ready = 1'b0;
    checks++;
    if (hgot.size() != TXD || hout.valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_count got=%0d v=%0b exp %0d/0",
               hgot.size(), hout.valid, TXD);
    end
    for (int i = 0; i < TXD && i < hgot.size(); i++) begin
      checks++;
      if (hgot[i] !== sent[i]) begin
        failures++;
        $display("FAIL fill_word%0d got=%h exp=%h", i, hgot[i], sent[i]);
      end
    end
    checks++;
    if (ft_txe_n !== 1'b0) begin
      failures++;
      $display("FAIL fill_txe_free got=%0b exp=0", ft_txe_n);
    end
  endtask

  task automatic test_underrun_async_reset();
    logic [31:0] sent[$];
    do_reset();
    fill_tx(sent);
    ft_oe_n = 1'b0;
    step();
    ft_rd_n = 1'b0;
    step();
    ft_rd_n = 1'b1;
    ft_oe_n = 1'b1;
    checks++;
    if (ft_data_o !== 32'h0 || err_flags[0] !== 1'b1) begin
      failures++;
      $display("FAIL underrun got d=%h err0=%0b exp 0/1",
               ft_data_o, err_flags[0]);
    end
    checks++;
    if (ft_txe_n !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_txe got=%0b exp=1", ft_txe_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (err_flags !== 4'h0 || ft_txe_n !== 1'b0 ||
        hout.valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got err=%h txe=%0b v=%0b exp 0/0/0",
               err_flags, ft_txe_n, hout.valid);
    end
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_conflict_be();
    logic [31:0] w2;
    do_reset();
    ft_oe_n = 1'b0;
    ft_wr_n = 1'b0;
    ft_data_i = $urandom;
    step();
    ft_wr_n = 1'b1;
    ft_oe_n = 1'b1;
    checks++;
    if (err_flags[2] !== 1'b1) begin
      failures++;
      $display("FAIL conflict got=%0b exp=1", err_flags[2]);
    end
    repeat (5) step();
    checks++;
    if (err_flags !== m_err || err_flags[2] !== 1'b1) begin
      failures++;
      $display("FAIL conflict_sticky got=%h exp=%h", err_flags, m_err);
    end
    w2 = $urandom;
    ft_wr_n = 1'b0;
    ft_be_i = 4'h3;
    ft_data_i = w2;
    step();
    ft_wr_n = 1'b1;
    ft_be_i = 4'hF;
    checks++;
    if (err_flags[3] !== 1'b1) begin
      failures++;
      $display("FAIL be_error got=%0b exp=1", err_flags[3]);
    end
    hgot.delete();
    hout.ready = 1'b1;
    repeat (3) step();
    hout.ready = 1'b0;
    checks++;
    if (hgot.size() != 2 || hgot[hgot.size()-1] !== bswap(w2)) begin
      failures++;
      $display("FAIL be_stored got n=%0d exp n=2 last=%h",
               hgot.size(), bswap(w2));
    end
  endtask

  task automatic test_random();
    int mode;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      mode = $urandom_range(0, 9);
      if (mode < 4) begin
        ft_oe_n = 1'b0;
        ft_rd_n = 1'($urandom_range(0, 1));
        ft_wr_n = 1'b1;
      end else if (mode < 9) begin
        ft_oe_n = 1'b1;
        ft_rd_n = 1'b1;
        ft_wr_n = 1'($urandom_range(0, 1));
      end else begin
        ft_oe_n = 1'($urandom_range(0, 1));
        ft_rd_n = 1'($urandom_range(0, 1));
        ft_wr_n = 1'($urandom_range(0, 1));
      end
      ft_be_i = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
      ft_data_i = $urandom;
      hin.valid = 1'($urandom_range(0, 1));
      hin.data = $urandom;
      hout.ready = ($urandom_range(0, 2) != 0);
      step();
      checks++;
      if (ft_data_o !== m_data || ft_data_oe !== m_oe) begin
        failures++;
        $display("FAIL rnd_bus c=%0d got d=%h oe=%0b exp d=%h oe=%0b",
                 c, ft_data_o, ft_data_oe, m_data, m_oe);
      end
      checks++;
      if (ft_rxf_n !== m_rxf || ft_txe_n !== m_txe) begin
        failures++;
        $display("FAIL rnd_flags c=%0d got rxf=%0b txe=%0b exp %0b/%0b",
                 c, ft_rxf_n, ft_txe_n, m_rxf, m_txe);
      end
      checks++;
      if (err_flags !== m_err) begin
        failures++;
        $display("FAIL rnd_err c=%0d got=%h exp=%h", c, err_flags, m_err);
      end
      checks++;
      if (hout.valid !== (txq.size() > 0) ||
          hin.ready !== (rxq.size() < RXD)) begin
        failures++;
        $display("FAIL rnd_host c=%0d got v=%0b rdy=%0b exp %0b/%0b",
                 c, hout.valid, hin.ready, txq.size() > 0,
                 rxq.size() < RXD);
      end
      if (txq.size() > 0) begin
        checks++;
        if (hout.data !== txq[0]) begin
          failures++;
          $display("FAIL rnd_dout c=%0d got=%h exp=%h",
                   c, hout.data, txq[0]);
        end
      end
    end
    idle();
  endtask

`ifdef PCILEECH_FT601_EMU_TXBURST_EN
  task automatic test_burst();
    logic [31:0] words[20];
    int idx, hi;
    do_reset();
    for (int i = 0; i < 20; i++) words[i] = $urandom;
    hout.ready = 1'b1;
    idx = 0;
    hi = 0;
    for (int g = 0; g < 200 && idx < 20; g++) begin
      ft_wr_n = 1'b0;
      ft_data_i = words[idx];
      if (!m_txe) idx++;
      step();
      if (ft_txe_n === 1'b1) hi++;
      checks++;
      if (ft_txe_n !== m_txe) begin
        failures++;
        $display("FAIL burst_txe g=%0d got=%0b exp=%0b",
                 g, ft_txe_n, m_txe);
      end
    end
    ft_wr_n = 1'b1;
    for (int g = 0; g < 40 && hout.valid === 1'b1; g++) step();
    checks++;
    if (hi != 2 * HOLD || hgot.size() != 20) begin
      failures++;
      $display("FAIL burst_shape got hi=%0d n=%0d exp %0d/20",
               hi, hgot.size(), 2 * HOLD);
    end
    for (int i = 0; i < 20 && i < hgot.size(); i++) begin
      checks++;
      if (hgot[i] !== bswap(words[i])) begin
        failures++;
        $display("FAIL burst_word%0d got=%h exp=%h",
                 i, hgot[i], bswap(words[i]));
      end
    end
    idle();
  endtask
`endif

  initial begin
    idle();
    model_reset();
    test_reset();
    test_rx_read();
    test_tx_write();
    test_tx_fill();
    test_underrun_async_reset();
    test_conflict_be();
    test_random();
`ifdef PCILEECH_FT601_EMU_TXBURST_EN
    test_burst();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
